// File: rtl/dmem_bus_ctrl_if.sv
// Data-memory bus bundle.
// Controller drives the request side; memory drives the response side.
interface dmem_bus_ctrl_if;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_mask_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_valid_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_mask_o,
    output mem_wdata_o,
    input  mem_ready_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_valid_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_mask_o,
    input  mem_wdata_o,
    output mem_ready_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller behind the memory stage.
// One access in flight; stalls the pipe until the bus completes.
module dmem_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  dmem_bus_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             latch;
  logic             cap;
  logic             tout;
  logic             busy_q;
  logic             busy_d;

  assign cnt_inc = cnt_q + 1'b1;
  assign hit     = TO_EN && (cnt_inc == TO_LIM);
  assign busy_q  = (state_q == REQ) ||
                   (state_q == WAIT);
  assign busy_d  = (state_d == REQ) ||
                   (state_d == WAIT);

  // next state, stall, valid and capture strobes
  always_comb begin
    state_d         = state_q;
    stall_o         = 1'b0;
    bus.mem_valid_o = 1'b0;
    latch           = 1'b0;
    cap             = 1'b0;
    tout            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          stall_o = 1'b1;
          latch   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_o         = 1'b1;
        bus.mem_valid_o = 1'b1;
        if (bus.mem_ready_i) begin
          if (bus.mem_we_o) begin
            state_d = DONE;
          end else if (bus.mem_rvalid_i) begin
            cap     = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (hit) begin
          tout    = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (bus.mem_rvalid_i) begin
          cap     = 1'b1;
          state_d = DONE;
        end else if (hit) begin
          tout    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register and timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (busy_q && busy_d) begin
        cnt_q <= cnt_inc;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // bus request registers, held until the access ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_mask_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else if (latch) begin
      bus.mem_we_o    <= we_i;
      bus.mem_addr_o  <= {addr_i[31:2], 2'b00};
      bus.mem_mask_o  <= mask_i;
      bus.mem_wdata_o <= wdata_i;
    end
  end

  // load data and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (tout) begin
        rdata_o <= '0;
        err_o   <= 1'b1;
      end else if (cap) begin
        rdata_o <= bus.mem_rdata_i;
      end
    end
  end

endmodule
